// File: rtl/handshake_rr_merge_arbiter.sv
// Round-robin merge of NUM_INPUTS valid/ready channels into one registered output slot
// that carries the winning payload and its input index.
module handshake_rr_merge_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
    input  logic [NUM_INPUTS-1:0]            ins_valid,
    output logic [NUM_INPUTS-1:0]            ins_ready,
    output logic [DATA_WIDTH-1:0]            outs,
    output logic [INDEX_WIDTH-1:0]           outs_index,
    output logic                             outs_valid,
    input  logic                             outs_ready
);

    logic [INDEX_WIDTH-1:0] ptr_r;
    logic [DATA_WIDTH-1:0]  outs_r;
    logic [INDEX_WIDTH-1:0] outs_index_r;
    logic                   outs_valid_r;

    logic [NUM_INPUTS-1:0]  at_or_above_ptr_s;
    logic [NUM_INPUTS-1:0]  upper_req_s;
    logic [NUM_INPUTS-1:0]  search_req_s;
    logic [NUM_INPUTS-1:0]  grant_onehot_s;
    logic                   grant_found_s;
    logic                   can_accept_s;
    logic                   accept_s;
    logic [INDEX_WIDTH-1:0] grant_idx_s;
    logic [DATA_WIDTH-1:0]  grant_data_s;
    logic [INDEX_WIDTH-1:0] next_ptr_s;

    // Mask of inputs whose index is at or above the priority pointer.
    always_comb begin
        at_or_above_ptr_s = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            at_or_above_ptr_s[i] = (i >= int'(ptr_r));
        end
    end

    // Prefer requesters at/after ptr; fall back to the wrapped range. Lowest set bit wins.
    assign upper_req_s    = ins_valid & at_or_above_ptr_s;
    assign search_req_s   = (upper_req_s != '0) ? upper_req_s : ins_valid;
    assign grant_onehot_s = search_req_s & (~search_req_s + NUM_INPUTS'(1));
    assign grant_found_s  = (ins_valid != '0);

    // Encode the one-hot grant into an index and select the matching payload.
    always_comb begin
        grant_idx_s  = '0;
        grant_data_s = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            grant_idx_s  = grant_idx_s  | (grant_onehot_s[i] ? INDEX_WIDTH'(i) : '0);
            grant_data_s = grant_data_s | (grant_onehot_s[i] ? ins[i*DATA_WIDTH +: DATA_WIDTH] : '0);
        end
    end

    // The slot can take a token when empty or when its current token leaves this cycle.
    assign can_accept_s = !outs_valid_r || outs_ready;
    assign accept_s     = grant_found_s && can_accept_s;
    assign ins_ready    = can_accept_s ? grant_onehot_s : '0;
    assign next_ptr_s   = (grant_idx_s == INDEX_WIDTH'(NUM_INPUTS - 1))
                        ? '0 : (grant_idx_s + INDEX_WIDTH'(1));

    // Output slot and priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outs_r       <= '0;
            outs_index_r <= '0;
            outs_valid_r <= 1'b0;
            ptr_r        <= '0;
        end else if (accept_s) begin
            outs_r       <= grant_data_s;
            outs_index_r <= grant_idx_s;
            outs_valid_r <= 1'b1;
            ptr_r        <= next_ptr_s;
        end else if (outs_valid_r && outs_ready) begin
            outs_valid_r <= 1'b0;
        end else begin
            outs_valid_r <= outs_valid_r;
        end
    end

    assign outs       = outs_r;
    assign outs_index = outs_index_r;
    assign outs_valid = outs_valid_r;

endmodule

// File: tb/tb_handshake_rr_merge_arbiter.sv
// Scoreboard bench for handshake_rr_merge_arbiter: a 4-input and a 3-input instance,
// directed phases plus randomized traffic against a queue-based reference model.
module tb_handshake_rr_merge_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        outs_ready_d = 1'b1;
    logic [3:0]  req_v = 4'd0;
    logic [31:0] req_d [4];

    logic [127:0] ins4;
    logic [95:0]  ins3;
    logic [3:0]   rdy4;
    logic [2:0]   rdy3;
    logic [31:0]  o4, o3;
    logic [1:0]   oi4, oi3;
    logic         ov4, ov3;

    assign ins4 = {req_d[3], req_d[2], req_d[1], req_d[0]};
    assign ins3 = {req_d[2], req_d[1], req_d[0]};

    handshake_rr_merge_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH(32), .INDEX_WIDTH(2)) dut4 (
        .clk(clk), .rst(rst), .ins(ins4), .ins_valid(req_v), .ins_ready(rdy4),
        .outs(o4), .outs_index(oi4), .outs_valid(ov4), .outs_ready(outs_ready_d));

    handshake_rr_merge_arbiter #(.NUM_INPUTS(3), .DATA_WIDTH(32), .INDEX_WIDTH(2)) dut3 (
        .clk(clk), .rst(rst), .ins(ins3), .ins_valid(req_v[2:0]), .ins_ready(rdy3),
        .outs(o3), .outs_index(oi3), .outs_valid(ov3), .outs_ready(outs_ready_d));

    // Observed view of whichever instance is under test.
    logic [3:0]  m_rdy;
    logic [31:0] m_o;
    logic [1:0]  m_oi;
    logic        m_ov;
    assign m_rdy = sel ? {1'b0, rdy3} : rdy4;
    assign m_o   = sel ? o3  : o4;
    assign m_oi  = sel ? oi3 : oi4;
    assign m_ov  = sel ? ov3 : ov4;

    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_pop   = 0;
    int mode    = 0;           // 0: no new requests, 1: fixed refill, 2: random
    logic [3:0] fixed_mask = 4'd0;

    // Reference model state
    int          m_ptr = 0;
    bit          m_slot_v = 1'b0;
    bit          acc_fire = 1'b0;
    int          acc_idx = 0;
    logic [33:0] sb [$];
    int          log_idx [$];
    logic [31:0] log_data [$];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle, predicts the grant taken at the next rising edge.
    always begin
        int n, g, c;
        bit can;
        logic [3:0] exp_rdy;
        @(negedge clk);
        #1;
        if (rst) begin
            acc_fire = 1'b0;
        end else begin
            n = sel ? 3 : 4;
            g = -1;
            for (int k = 0; k < n; k++) begin
                c = (m_ptr + k) % n;
                if (g < 0 && req_v[c]) g = c;
            end
            can = !m_slot_v || outs_ready_d;
            exp_rdy = 4'd0;
            if (g >= 0 && can) exp_rdy[g] = 1'b1;
            check("ins_ready", m_rdy, exp_rdy);
            if (g >= 0 && can) begin
                sb.push_back({req_d[g], 2'(g)});
                n_push++;
                m_ptr = (g + 1) % n;
                m_slot_v = 1'b1;
                acc_fire = 1'b1;
                acc_idx = g;
            end else begin
                acc_fire = 1'b0;
                if (m_slot_v && outs_ready_d) m_slot_v = 1'b0;
            end
        end
    end

    // Monitor: compares the presented output against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", m_ov, m_slot_v);
            if (m_ov && m_slot_v && sb.size() > 0) begin
                check("out_token", {m_o, m_oi}, sb[0]);
                if (outs_ready_d) begin
                    log_idx.push_back(int'(m_oi));
                    log_data.push_back(m_o);
                    void'(sb.pop_front());
                    n_pop++;
                end
            end
            if (sel) check("idx_range", {1'b0, m_oi == 2'd3}, 2'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_fire) req_v[acc_idx] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!req_v[i]) begin
                if (mode == 1 && fixed_mask[i]) begin
                    req_v[i] = 1'b1;
                    req_d[i] = 32'hA0 + 32'(i);
                end else if (mode == 2 && i < (sel ? 3 : 4) && $urandom_range(0, 1) == 1) begin
                    req_v[i] = 1'b1;
                    req_d[i] = $urandom;
                end
            end
        end
        if (mode == 2) outs_ready_d = ($urandom_range(0, 3) != 0);
    endtask

    // Asserts reset between clock edges, checks the immediate clear, holds, then releases.
    task automatic hard_reset(input int hold, input bit new_sel);
        #2;
        rst = 1'b1;
        sel = new_sel;
        sb.delete();
        m_slot_v = 1'b0;
        m_ptr = 0;
        acc_fire = 1'b0;
        req_v = 4'd0;
        mode = 0;
        n_push = 0;
        n_pop = 0;
        #1;
        check("rst_valid_now", m_ov, 1'b0);
        check("rst_outs_now", {m_o, m_oi}, 34'd0);
        repeat (hold) begin
            step();
            check("rst_hold", {m_ov, m_rdy, m_oi, m_o}, 39'd0);
        end
        #2;
        rst = 1'b0;
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_data.delete();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_d[i] = 32'd0;

        // Reset and idle
        hard_reset(3, 1'b0);
        repeat (10) begin
            step();
            check("idle", {m_ov, m_rdy, m_oi, m_o}, 39'd0);
        end

        // Full contention
        fixed_mask = 4'hF;
        mode = 1;
        outs_ready_d = 1'b1;
        clear_log();
        repeat (8) step();
        check("full_count", {31'd0, log_idx.size() >= 6}, 32'd1);
        for (int k = 0; k < 6 && k < log_idx.size(); k++) begin
            check("full_order", log_idx[k], k % 4);
            check("full_data", log_data[k], 32'hA0 + 32'(k % 4));
        end

        // Sparse requests on inputs 1 and 3
        hard_reset(2, 1'b0);
        fixed_mask = 4'b1010;
        mode = 1;
        clear_log();
        repeat (8) step();
        check("sparse_count", {31'd0, log_idx.size() >= 4}, 32'd1);
        for (int k = 0; k < 4 && k < log_idx.size(); k++)
            check("sparse_order", log_idx[k], (k % 2 == 0) ? 1 : 3);

        // Backpressure
        hard_reset(2, 1'b0);
        outs_ready_d = 1'b1;
        req_v[2] = 1'b1;
        req_d[2] = 32'h55;
        step();
        req_v[0] = 1'b1; req_d[0] = 32'h10;
        req_v[3] = 1'b1; req_d[3] = 32'h13;
        outs_ready_d = 1'b0;
        clear_log();
        repeat (5) begin
            step();
            check("stall_hold", {m_ov, m_rdy, m_oi, m_o}, {1'b1, 4'd0, 2'd2, 32'h55});
        end
        outs_ready_d = 1'b1;
        step();
        check("stall_release", {m_ov, m_oi, m_o}, {1'b1, 2'd3, 32'h13});
        check("stall_first_out", (log_idx.size() > 0) ? log_idx[0] : -1, 2);

        // Reset mid-operation with ptr at 2 and a stalled token
        hard_reset(2, 1'b0);
        outs_ready_d = 1'b0;
        req_v[1] = 1'b1; req_d[1] = 32'h21;
        step();
        req_v[0] = 1'b1; req_d[0] = 32'h30;
        req_v[2] = 1'b1; req_d[2] = 32'h32;
        req_v[3] = 1'b1; req_d[3] = 32'h33;
        step();
        check("midop_loaded", {m_ov, m_oi, m_o}, {1'b1, 2'd1, 32'h21});
        hard_reset(2, 1'b0);
        req_v = 4'b1101;
        outs_ready_d = 1'b1;
        clear_log();
        repeat (3) step();
        check("midop_first", (log_idx.size() > 0) ? log_idx[0] : -1, 0);
        check("midop_data", (log_data.size() > 0) ? log_data[0] : 32'hFFFF_FFFF, 32'h30);

        // Random traffic, four inputs
        hard_reset(2, 1'b0);
        mode = 2;
        repeat (400) step();

        // Three-input instance, ready toggling
        hard_reset(2, 1'b1);
        fixed_mask = 4'b0111;
        mode = 1;
        outs_ready_d = 1'b1;
        clear_log();
        repeat (16) begin
            step();
            outs_ready_d = ~outs_ready_d;
        end
        check("np2_count", {31'd0, log_idx.size() >= 4}, 32'd1);
        for (int k = 0; k < 4 && k < log_idx.size(); k++)
            check("np2_order", log_idx[k], (k == 3) ? 0 : k);

        // Random traffic on the three-input instance, then drain
        hard_reset(2, 1'b1);
        mode = 2;
        repeat (400) step();
        mode = 0;
        outs_ready_d = 1'b1;
        for (int t = 0; t < 50 && !(req_v == 4'd0 && !m_slot_v); t++) step();
        repeat (2) step();
        check("drain_idle", {req_v, m_slot_v, m_ov}, 6'd0);
        check("drain_counts", n_pop, n_push);
        check("drain_sb", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
